// File: rtl/pair_decode_monitor.sv
// pair_decode_monitor: recovers {in1,in2} from encoded {out1,out2} pairs
// (out1 = in1^in2, out2 = ~in2) and checks the recovered stream against an
// incrementing 2-bit sequence, reporting lock and saturating error counts.
module pair_decode_monitor #(
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned LOCK_N = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enc_valid,
    input  logic             enc_out1,
    input  logic             enc_out2,
    input  logic             clr_count,
    output logic             dec_valid,
    output logic             dec_in1,
    output logic             dec_in2,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count
);

    localparam int unsigned RUN_W = 8;
    localparam int unsigned VAL_W = 2;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [RUN_W-1:0] LOCK_RUN = RUN_W'(LOCK_N);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HUNT   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t             state;
    logic [VAL_W-1:0]   prev;
    logic [RUN_W-1:0]   run;

    logic [VAL_W-1:0]   v_c;
    logic               good_c;
    logic [RUN_W-1:0]   run_inc_c;
    logic               lock_hit_c;

    // Decode the incoming pair and classify the step relative to prev
    always_comb begin
        v_c        = {enc_out1 ^ ~enc_out2, ~enc_out2};
        good_c     = (v_c == VAL_W'(prev + VAL_W'(1)));
        run_inc_c  = RUN_W'(run + RUN_W'(1));
        lock_hit_c = (run_inc_c == LOCK_RUN);
    end

    // Sequence tracker FSM with registered decode, lock and error outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            prev      <= '0;
            run       <= '0;
            dec_valid <= 1'b0;
            dec_in1   <= 1'b0;
            dec_in2   <= 1'b0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            dec_valid <= enc_valid;
            err_pulse <= 1'b0;
            if (clr_count) begin
                err_count <= '0;
            end
            if (enc_valid) begin
                dec_in1 <= v_c[1];
                dec_in2 <= v_c[0];
                prev    <= v_c;
                case (state)
                    IDLE: begin
                        run    <= '0;
                        state  <= HUNT;
                        locked <= 1'b0;
                    end
                    HUNT: begin
                        if (good_c) begin
                            run <= run_inc_c;
                            if (lock_hit_c) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end
                        end else begin
                            run <= '0;
                        end
                    end
                    LOCKED: begin
                        if (!good_c) begin
                            err_pulse <= 1'b1;
                            run       <= '0;
                            state     <= HUNT;
                            locked    <= 1'b0;
                            // clear wins over a coincident increment
                            if (!clr_count && (err_count != CNT_MAX)) begin
                                err_count <= CNT_W'(err_count + CNT_W'(1));
                            end
                        end
                    end
                    default: begin
                        run    <= '0;
                        state  <= IDLE;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pair_decode_monitor.sv
// Bench for pair_decode_monitor: two instances (default and CNT_W=2/LOCK_N=1)
// share one directed stimulus stream; a streak-based model predicts outputs.
module tb_pair_decode_monitor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       enc_valid = 1'b0;
    logic       enc_out1 = 1'b0;
    logic       enc_out2 = 1'b0;
    logic       clr_count = 1'b0;

    logic       dv0, a10, a20, lk0, ep0;
    logic [7:0] ec0;
    logic       dv1, a11, a21, lk1, ep1;
    logic [1:0] ec1;

    int n_vec = 0;
    int n_err = 0;
    int cur_v = 0;

    pair_decode_monitor #(.CNT_W(8), .LOCK_N(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .enc_valid(enc_valid), .enc_out1(enc_out1),
        .enc_out2(enc_out2), .clr_count(clr_count), .dec_valid(dv0),
        .dec_in1(a10), .dec_in2(a20), .locked(lk0), .err_pulse(ep0),
        .err_count(ec0)
    );

    pair_decode_monitor #(.CNT_W(2), .LOCK_N(1)) u_sat (
        .clk(clk), .rst_n(rst_n), .enc_valid(enc_valid), .enc_out1(enc_out1),
        .enc_out2(enc_out2), .clr_count(clr_count), .dec_valid(dv1),
        .dec_in1(a11), .dec_in2(a21), .locked(lk1), .err_pulse(ep1),
        .err_count(ec1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model: streak of consecutive good steps ----------------
    function automatic int lim(input int k);
        return (k == 0) ? 4 : 1;
    endfunction
    function automatic int cmax(input int k);
        return (k == 0) ? 255 : 3;
    endfunction

    bit e_valid = 1'b0;
    int e_in = 0;
    bit m_have[2] = '{0, 0};
    int m_prev[2] = '{0, 0};
    int m_streak[2] = '{0, 0};
    int m_cnt[2] = '{0, 0};
    bit m_err[2] = '{0, 0};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_valid = 1'b0;
            e_in = 0;
            for (int k = 0; k < 2; k++) begin
                m_have[k] = 1'b0; m_prev[k] = 0; m_streak[k] = 0;
                m_cnt[k] = 0; m_err[k] = 1'b0;
            end
        end else begin
            e_valid = enc_valid;
            if (enc_valid) e_in = cur_v;
            for (int k = 0; k < 2; k++) begin
                m_err[k] = 1'b0;
                if (enc_valid) begin
                    if (m_have[k]) begin
                        if (cur_v == (m_prev[k] + 1) % 4) begin
                            m_streak[k]++;
                        end else begin
                            m_err[k] = (m_streak[k] >= lim(k));
                            m_streak[k] = 0;
                        end
                    end
                    m_have[k] = 1'b1;
                    m_prev[k] = cur_v;
                end
                if (clr_count) m_cnt[k] = 0;
                else if (m_err[k] && m_cnt[k] < cmax(k)) m_cnt[k]++;
            end
        end
    end

    // Compare both instances against the model every cycle
    always @(negedge clk) begin
        chk("dec_valid0", int'(dv0), int'(e_valid));
        chk("dec_in1_0", int'(a10), (e_in >> 1) & 1);
        chk("dec_in2_0", int'(a20), e_in & 1);
        chk("locked0", int'(lk0), int'(m_streak[0] >= lim(0) && m_have[0]));
        chk("err_pulse0", int'(ep0), int'(m_err[0]));
        chk("err_count0", int'(ec0), m_cnt[0]);
        chk("dec_valid1", int'(dv1), int'(e_valid));
        chk("dec_in1_1", int'(a11), (e_in >> 1) & 1);
        chk("dec_in2_1", int'(a21), e_in & 1);
        chk("locked1", int'(lk1), int'(m_streak[1] >= lim(1) && m_have[1]));
        chk("err_pulse1", int'(ep1), int'(m_err[1]));
        chk("err_count1", int'(ec1), m_cnt[1]);
    end

    // ---------------- stimulus ----------------
    task automatic send(input int v, input bit valid = 1'b1, input bit clr = 1'b0);
        @(negedge clk);
        #1;
        cur_v     = v;
        enc_valid = valid;
        clr_count = clr;
        enc_out2  = ~v[0];
        enc_out1  = v[1] ^ v[0];
    endtask

    task automatic send_raw(input bit o1, input bit o2, input int v);
        @(negedge clk);
        #1;
        cur_v     = v;
        enc_valid = 1'b1;
        clr_count = 1'b0;
        enc_out1  = o1;
        enc_out2  = o2;
    endtask

    task automatic after_edge;
        @(posedge clk);
        #1;
    endtask

    int raw_o1[4] = '{0, 1, 1, 0};
    int raw_o2[4] = '{1, 0, 1, 0};
    int raw_v[4]  = '{0, 1, 2, 3};
    int sat_good[5] = '{2, 1, 0, 3, 2};
    int sat_skip[5] = '{0, 3, 2, 1, 0};
    int sat_cnt[5]  = '{1, 2, 3, 3, 3};
    int relock[5]   = '{1, 2, 3, 0, 1};

    initial begin
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dec_valid", int'(dv0), 0);
        chk("rst_locked", int'(lk0), 0);
        chk("rst_err_count", int'(ec0), 0);
        @(negedge clk);
        #1 rst_n = 1'b1;

        // decode table, first sample is the IDLE sample
        for (int i = 0; i < 4; i++) begin
            send_raw(raw_o1[i][0], raw_o2[i][0], raw_v[i]);
            after_edge();
            chk("tbl_valid", int'(dv0), 1);
            chk("tbl_in", int'({a10, a20}), raw_v[i]);
            chk("tbl_unlocked", int'(lk0), 0);
        end

        // fifth sample completes the 4th good step
        send(0);
        after_edge();
        chk("lock_rise", int'(lk0), 1);
        chk("lock_cnt", int'(ec0), 0);

        // error while locked: 0 -> 2
        send(2);
        after_edge();
        chk("err_pulse", int'(ep0), 1);
        chk("err_cnt1", int'(ec0), 1);
        chk("err_unlock", int'(lk0), 0);
        send(3);
        after_edge();
        chk("err_pulse_one", int'(ep0), 0);
        send(0); send(1); send(2);
        after_edge();
        chk("relock", int'(lk0), 1);

        // gaps hold state and outputs
        send(0, 1'b0); send(1, 1'b0); send(2, 1'b0);
        after_edge();
        chk("gap_locked", int'(lk0), 1);
        chk("gap_hold_in", int'({a10, a20}), 2);
        chk("gap_valid", int'(dv0), 0);
        send(3);
        after_edge();
        chk("gap_good", int'(lk0), 1);

        // clear coincident with an error
        send(1, 1'b1, 1'b1);
        after_edge();
        chk("clr_pulse", int'(ep0), 1);
        chk("clr_cnt", int'(ec0), 0);

        // saturation on the CNT_W=2 / LOCK_N=1 instance
        send(1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            send(sat_good[i]);
            after_edge();
            chk("sat_lock", int'(lk1), 1);
            send(sat_skip[i]);
            after_edge();
            chk("sat_pulse", int'(ep1), 1);
            chk("sat_cnt", int'(ec1), sat_cnt[i]);
        end

        // relock main instance, then async reset mid-cycle
        send(0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) send(relock[i]);
        after_edge();
        chk("pre_rst_lock", int'(lk0), 1);
        #2 rst_n = 1'b0;
        enc_valid = 1'b0;
        #1;
        chk("arst_valid", int'(dv0), 0);
        chk("arst_in", int'({a10, a20}), 0);
        chk("arst_locked", int'(lk0), 0);
        chk("arst_cnt", int'(ec0), 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) send(relock[i]);
        after_edge();
        chk("post_rst_lock", int'(lk0), 1);
        chk("post_rst_pulse", int'(ep0), 0);
        chk("post_rst_cnt", int'(ec0), 0);

        send(0, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
